// File: rtl/ap_hs_call_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs callee between N_REQ requesters.
// Define AP_HS_CALL_ARBITER_TIMEOUT_EN to add a done-watchdog and the timeout_err port.
module ap_hs_call_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ARG_W          = 32,
    parameter int RET_W          = 32,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*ARG_W-1:0] req_arg,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [RET_W-1:0]       rsp_data,
    output logic                   callee_ap_start,
    input  logic                   callee_ap_ready,
    input  logic                   callee_ap_done,
    input  logic [RET_W-1:0]       callee_ap_return,
    output logic [ARG_W-1:0]       callee_arg,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [31:0]            calls_done
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic [ID_W:0]   cand;
    logic            to_hit;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign req_ready = (state == IDLE && win_found) ? onehot(win_idx) : '0;

`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            rr_ptr          <= ID_W'(N_REQ - 1);
            callee_ap_start <= 1'b0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            callee_arg      <= '0;
            grant_id        <= '0;
            calls_done      <= '0;
            busy            <= 1'b0;
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
            to_cnt          <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        callee_arg      <= req_arg[win_idx*ARG_W +: ARG_W];
                        grant_id        <= win_idx;
                        rr_ptr          <= win_idx;
                        callee_ap_start <= 1'b1;
                        busy            <= 1'b1;
                        state           <= START;
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
                        to_cnt          <= '0;
`endif
                    end
                end
                START, WAIT: begin
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
                    to_cnt <= to_cnt + TO_W'(1);
`endif
                    // Done wins over ready: a zero-latency callee skips WAIT.
                    if (callee_ap_done) begin
                        rsp_data        <= callee_ap_return;
                        callee_ap_start <= 1'b0;
                        rsp_valid       <= onehot(grant_id);
                        state           <= RESP;
                    end else if (to_hit) begin
                        rsp_data        <= '0;
                        callee_ap_start <= 1'b0;
                        rsp_valid       <= onehot(grant_id);
                        state           <= RESP;
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
                        timeout_err     <= 1'b1;
`endif
                    end else if (state == START && callee_ap_ready) begin
                        callee_ap_start <= 1'b0;
                        state           <= WAIT;
                    end
                end
                RESP: begin
                    calls_done <= calls_done + 32'd1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_hs_call_arbiter.sv
// Scoreboard bench for ap_hs_call_arbiter with a behavioural ap_ctrl_hs callee.
module tb_ap_hs_call_arbiter;
    localparam int N_REQ = 4, ARG_W = 32, RET_W = 32, ID_W = 2, TIMEOUT_CYCLES = 16;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ*ARG_W-1:0] req_arg = '0;
    logic [N_REQ-1:0]       req_ready, rsp_valid;
    logic [RET_W-1:0]       rsp_data;
    logic                   callee_ap_start;
    logic                   callee_ap_ready = 1'b0;
    logic                   callee_ap_done = 1'b0;
    logic [RET_W-1:0]       callee_ap_return = '0;
    logic [ARG_W-1:0]       callee_arg;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;
    logic [31:0]            calls_done;
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
    logic                   timeout_err;
`endif

    ap_hs_call_arbiter #(.N_REQ(N_REQ), .ARG_W(ARG_W), .RET_W(RET_W), .ID_W(ID_W),
                         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_arg(req_arg),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .callee_ap_start(callee_ap_start), .callee_ap_ready(callee_ap_ready),
        .callee_ap_done(callee_ap_done), .callee_ap_return(callee_ap_return),
        .callee_arg(callee_arg), .busy(busy), .grant_id(grant_id), .calls_done(calls_done)
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0;
    typedef struct {int id; logic [RET_W-1:0] data;} exp_t;
    exp_t exp_q[$];
    int   gnt_q[$];

    int               cal_rdy_dly = 0, cal_lat = 0, cal_cnt = 0;
    bit               cal_hang = 0, cal_fixed = 0, cal_active = 0;
    logic [RET_W-1:0] cal_fixed_val = '0;
    logic [ARG_W-1:0] cal_arg = '0;

    function automatic logic [RET_W-1:0] ret_of(input logic [ARG_W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Callee model: latches its argument on ap_start, raises ap_ready after
    // cal_rdy_dly cycles and ap_done after cal_lat cycles.
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            cal_active = 0;
            cal_cnt    = 0;
        end else if (cal_active) begin
            if (callee_ap_done) cal_active = 0;
            else cal_cnt++;
        end else if (callee_ap_start) begin
            cal_active = 1;
            cal_cnt    = 0;
            cal_arg    = callee_arg;
        end
        callee_ap_ready  = cal_active && (cal_cnt == cal_rdy_dly);
        callee_ap_done   = cal_active && !cal_hang && (cal_cnt == cal_lat);
        callee_ap_return = cal_fixed ? cal_fixed_val : ret_of(cal_arg);
    end

    // Scoreboard: every response is matched against the queue; grants are logged.
    always @(negedge clock) begin
        exp_t e;
        if (rsp_valid !== '0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: rsp_valid=%b rsp_data=%h, required no response", rsp_valid, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_valid !== N_REQ'(1 << e.id) || rsp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL rsp_check: rsp_valid=%b rsp_data=%h, required %b %h",
                             rsp_valid, rsp_data, N_REQ'(1 << e.id), e.data);
                end
            end
        end
        if (req_ready !== '0) begin
            vectors++;
            if (!$onehot(req_ready)) begin
                miscompares++;
                $display("FAIL req_ready_onehot: req_ready=%b, required one-hot", req_ready);
            end
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gnt_q.push_back(i);
        end
    end

    task automatic apply_reset();
        @(posedge clock); #2;
        reset = 0; req_valid = '0;
        repeat (2) @(posedge clock);
        #2 reset = 1;
        exp_q.delete(); gnt_q.delete();
        cal_rdy_dly = 0; cal_lat = 0; cal_hang = 0; cal_fixed = 0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock); #1;
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({busy, callee_ap_start, req_ready, rsp_valid, rsp_data, callee_arg, grant_id, calls_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b start=%b rdy=%b rsp=%b data=%h arg=%h gid=%0d calls=%0d, required all 0",
                     busy, callee_ap_start, req_ready, rsp_valid, rsp_data, callee_arg, grant_id, calls_done);
        end
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_timeout_err: got %b, required 0", timeout_err);
        end
`endif
        @(posedge clock); #2 reset = 1;
        req_valid = 4'b1110;
        #1 vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_priority_a: req_ready=%b, required 0010", req_ready);
        end
        req_valid = 4'b1111;
        #1 vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_priority_b: req_ready=%b, required 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_call();
        bit ok;
        apply_reset();
        cal_rdy_dly = 2; cal_lat = 5; cal_fixed = 1; cal_fixed_val = 32'h7;
        @(posedge clock); #2;
        req_arg[2*ARG_W +: ARG_W] = 32'h15;
        req_valid = 4'b0100;
        exp_q.push_back('{2, 32'h7});
        @(negedge clock);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready: req_ready=%b, required 0100", req_ready);
        end
        @(posedge clock); #2 req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            vectors++;
            if (callee_ap_start !== 1'b1 || callee_arg !== 32'h15 || grant_id !== 2'd2 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_start_held[%0d]: start=%b arg=%h gid=%0d busy=%b, required 1 15 2 1",
                         k, callee_ap_start, callee_arg, grant_id, busy);
            end
        end
        @(negedge clock);
        vectors++;
        if (callee_ap_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_start_drop: start=%b, required 0 after ap_ready", callee_ap_start);
        end
        wait_drain(20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_timeout: response count 0, required 1"); end
        @(negedge clock);
        repeat (3) @(negedge clock);
        vectors++;
        if (calls_done !== 32'd1 || busy !== 1'b0 || rsp_data !== 32'h7) begin
            miscompares++;
            $display("FAIL single_after: calls=%0d busy=%b data=%h, required 1 0 7", calls_done, busy, rsp_data);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        cal_rdy_dly = 0; cal_lat = 2;
        @(posedge clock); #2;
        for (int i = 0; i < N_REQ; i++) req_arg[i*ARG_W +: ARG_W] = 32'h100 + 32'(i * 17);
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{order[i], ret_of(32'h100 + 32'(order[i] * 17))});
        for (int c = 0; c < 80; c++) begin
            @(negedge clock); #1;
            if (gnt_q.size() >= 5) break;
        end
        @(posedge clock); #2 req_valid = '0;
        wait_drain(40, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL contention_timeout: %0d responses pending, required 0", exp_q.size()); end
        repeat (2) @(negedge clock);
        vectors++;
        if (gnt_q.size() != 5) begin
            miscompares++;
            $display("FAIL contention_grants: %0d grants, required 5", gnt_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (gnt_q[i] != order[i]) begin
                    miscompares++;
                    $display("FAIL contention_order[%0d]: granted %0d, required %0d", i, gnt_q[i], order[i]);
                end
            end
        end
        vectors++;
        if (calls_done !== 32'd5) begin
            miscompares++;
            $display("FAIL contention_calls: calls_done=%0d, required 5", calls_done);
        end
    endtask

    task automatic test_zero_latency();
        bit ok;
        apply_reset();
        cal_rdy_dly = 0; cal_lat = 0;
        @(posedge clock); #2;
        req_arg[3*ARG_W +: ARG_W] = 32'hBEEF;
        req_valid = 4'b1000;
        exp_q.push_back('{3, ret_of(32'hBEEF)});
        @(negedge clock);
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL zl_ready: req_ready=%b, required 1000", req_ready);
        end
        @(posedge clock); #2 req_valid = '0;
        @(negedge clock);
        vectors++;
        if (callee_ap_start !== 1'b1 || rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL zl_t1: start=%b rsp=%b, required 1 0000", callee_ap_start, rsp_valid);
        end
        @(negedge clock);
        vectors++;
        if (callee_ap_start !== 1'b0 || rsp_valid !== 4'b1000) begin
            miscompares++;
            $display("FAIL zl_t2: start=%b rsp=%b, required 0 1000", callee_ap_start, rsp_valid);
        end
        @(negedge clock);
        vectors++;
        if (callee_ap_start !== 1'b0 || rsp_valid !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zl_t3: start=%b rsp=%b busy=%b, required 0 0000 0", callee_ap_start, rsp_valid, busy);
        end
        wait_drain(5, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL zl_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_withdrawal();
        bit ok;
        apply_reset();
        cal_rdy_dly = 1; cal_lat = 6;
        @(posedge clock); #2;
        req_arg[0 +: ARG_W] = 32'h21;
        req_valid = 4'b0001;
        exp_q.push_back('{0, ret_of(32'h21)});
        @(posedge clock); #2 req_valid = '0;
        @(posedge clock); #2;
        req_arg[ARG_W +: ARG_W] = 32'h33;
        req_valid = 4'b0010;
        repeat (2) @(posedge clock);
        #2 req_valid = '0;
        wait_drain(20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL withdraw_drain: %0d pending, required 0", exp_q.size()); end
        repeat (6) @(negedge clock);
        vectors++;
        if (gnt_q.size() != 1 || gnt_q[0] != 0) begin
            miscompares++;
            $display("FAIL withdraw_grants: %0d grants (first %0d), required exactly one grant to 0",
                     gnt_q.size(), gnt_q.size() > 0 ? gnt_q[0] : -1);
        end
        vectors++;
        if (calls_done !== 32'd1) begin
            miscompares++;
            $display("FAIL withdraw_calls: calls_done=%0d, required 1", calls_done);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        apply_reset();
        cal_rdy_dly = 0; cal_lat = 10;
        @(posedge clock); #2;
        req_arg[2*ARG_W +: ARG_W] = 32'h44;
        req_valid = 4'b0100;
        @(posedge clock); #2 req_valid = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (busy !== 1'b1 || callee_ap_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rmw_in_wait: busy=%b start=%b, required 1 0", busy, callee_ap_start);
        end
        @(posedge clock); #2 reset = 0;
        @(posedge clock); #2 reset = 1;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || callee_ap_start !== 1'b0 || calls_done !== 32'd0 || rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL rmw_after: busy=%b start=%b calls=%0d rsp=%b, required 0 0 0 0000",
                     busy, callee_ap_start, calls_done, rsp_valid);
        end
        repeat (12) @(negedge clock);
        gnt_q.delete();
        @(posedge clock); #2;
        req_arg[0 +: ARG_W] = 32'h55;
        req_arg[3*ARG_W +: ARG_W] = 32'h66;
        cal_lat = 1;
        req_valid = 4'b1001;
        exp_q.push_back('{0, ret_of(32'h55)});
        @(negedge clock);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rmw_next_grant: req_ready=%b, required 0001", req_ready);
        end
        @(posedge clock); #2 req_valid = '0;
        wait_drain(20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rmw_drain: %0d pending, required 0", exp_q.size()); end
    endtask

`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit early;
        apply_reset();
        cal_rdy_dly = 0; cal_lat = 1;
        @(posedge clock); #2;
        req_arg[0 +: ARG_W] = 32'h9;
        req_valid = 4'b0001;
        exp_q.push_back('{0, ret_of(32'h9)});
        @(posedge clock); #2 req_valid = '0;
        wait_drain(20, ok);
        repeat (2) @(negedge clock);
        cal_hang = 1;
        @(posedge clock); #2;
        req_arg[ARG_W +: ARG_W] = 32'h77;
        req_valid = 4'b0010;
        exp_q.push_back('{1, 32'h0});
        @(posedge clock); #2 req_valid = '0;
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (rsp_valid !== '0 || callee_ap_start !== 1'b1) early = 1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL timeout_early: response or ap_start drop before 16 cycles, required none");
        end
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'h0 || timeout_err !== 1'b1 || callee_ap_start !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_rsp: rsp=%b data=%h err=%b start=%b, required 0010 0 1 0",
                     rsp_valid, rsp_data, timeout_err, callee_ap_start);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || calls_done !== 32'd2) begin
            miscompares++;
            $display("FAIL timeout_sticky: err=%b busy=%b calls=%0d, required 1 0 2", timeout_err, busy, calls_done);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_call();
        test_contention();
        test_zero_latency();
        test_withdrawal();
        test_reset_mid_wait();
`ifdef AP_HS_CALL_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
